// File: rtl/systolic_writeback_if.sv
// Result-collection bus between the systolic array, the writeback block and the lane banks.
// Array-side and bank-side signals share one bundle so lane widths stay consistent.
interface systolic_writeback_if #(
  parameter int D_W_ACC = 16,
  parameter int N1      = 4,
  parameter int M       = 8
);
  localparam int DEPTH = M * M / N1;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic                start;
  logic [D_W_ACC-1:0]  D       [N1];
  logic [N1-1:0]       valid_D;
  logic [N1-1:0]       wr_en;
  logic [AW-1:0]       wr_addr [N1];
  logic [D_W_ACC-1:0]  wr_data [N1];
  logic                busy;
  logic                done;
  logic                err_overflow;
  logic                err_idle;

  modport master (
    output start, D, valid_D,
    input  wr_en, wr_addr, wr_data, busy, done, err_overflow, err_idle
  );

  modport slave (
    input  start, D, valid_D,
    output wr_en, wr_addr, wr_data, busy, done, err_overflow, err_idle
  );
endinterface

// File: rtl/systolic_writeback.sv
// Collects one MxM result matrix from N1 staggered array rows and writes each row
// into its own bank with a fixed one-cycle latency; flags stray or excess beats.
module systolic_writeback #(
  parameter int D_W_ACC = 16,
  parameter int N1      = 4,
  parameter int M       = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  systolic_writeback_if.slave   io_wb
);
  localparam int DEPTH = M * M / N1;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COLLECT = 2'd1;
  localparam logic [1:0] S_DONE    = 2'd2;

  logic [1:0]          r_state;
  logic [AW-1:0]       r_cnt     [N1];
  logic [N1-1:0]       r_complete;
  logic [N1-1:0]       r_wr_en;
  logic [AW-1:0]       r_wr_addr [N1];
  logic [D_W_ACC-1:0]  r_wr_data [N1];
  logic                r_err_overflow;
  logic                r_err_idle;

  logic                w_collect;
  logic [N1-1:0]       w_accept;
  logic [N1-1:0]       w_last;
  logic                w_all_done;
  logic                w_overflow_hit;
  logic                w_idle_hit;

  always_comb begin
    w_last = '0;
    for (int i = 0; i < N1; i++) begin
      w_last[i] = (r_cnt[i] == LAST_ADDR);
    end
  end

  assign w_collect      = (r_state == S_COLLECT);
  assign w_accept       = io_wb.valid_D & ~r_complete & {N1{w_collect}};
  // Lanes finishing this very cycle count towards completion.
  assign w_all_done     = &(r_complete | (w_accept & w_last));
  assign w_overflow_hit = w_collect & (|(io_wb.valid_D & r_complete));
  assign w_idle_hit     = ~w_collect & (|io_wb.valid_D);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_complete     <= '0;
      r_wr_en        <= '0;
      r_err_overflow <= 1'b0;
      r_err_idle     <= 1'b0;
      for (int i = 0; i < N1; i++) begin
        r_cnt[i]     <= '0;
        r_wr_addr[i] <= '0;
        r_wr_data[i] <= '0;
      end
    end else begin
      r_wr_en <= w_accept;
      for (int i = 0; i < N1; i++) begin
        if (w_accept[i]) begin
          r_wr_addr[i] <= r_cnt[i];
          r_wr_data[i] <= io_wb.D[i];
          // Counter parks on the last address; completion is tracked separately.
          if (w_last[i]) begin
            r_complete[i] <= 1'b1;
          end else begin
            r_cnt[i] <= r_cnt[i] + AW'(1);
          end
        end
      end

      case (r_state)
        S_IDLE: begin
          if (io_wb.start) begin
            r_state        <= S_COLLECT;
            r_complete     <= '0;
            r_err_overflow <= 1'b0;
            r_err_idle     <= 1'b0;
            for (int i = 0; i < N1; i++) begin
              r_cnt[i] <= '0;
            end
          end
        end
        S_COLLECT: begin
          if (w_all_done) begin
            r_state <= S_DONE;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase

      // Error sets come last so a stray beat on the start cycle is still recorded.
      if (w_overflow_hit) begin
        r_err_overflow <= 1'b1;
      end
      if (w_idle_hit) begin
        r_err_idle <= 1'b1;
      end
    end
  end

  assign io_wb.wr_en        = r_wr_en;
  assign io_wb.wr_addr      = r_wr_addr;
  assign io_wb.wr_data      = r_wr_data;
  assign io_wb.busy         = w_collect;
  assign io_wb.done         = (r_state == S_DONE);
  assign io_wb.err_overflow = r_err_overflow;
  assign io_wb.err_idle     = r_err_idle;
endmodule

// File: tb/tb_systolic_writeback.sv
// Directed and randomized checks of systolic_writeback against a beat-counting reference model.
module tb_systolic_writeback;
  localparam int D_W_ACC = 16;
  localparam int N1      = 4;
  localparam int M       = 8;
  localparam int DEPTH   = M * M / N1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  systolic_writeback_if #(.D_W_ACC(D_W_ACC), .N1(N1), .M(M)) bus ();

  systolic_writeback #(.D_W_ACC(D_W_ACC), .N1(N1), .M(M)) dut (
    .clk   (clk),
    .rst   (rst),
    .io_wb (bus.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int done_cnt;

  // Reference model: phase 0 idle, 1 collecting, 2 done cycle; m_cnt = beats accepted so far.
  int                 m_phase;
  int                 m_cnt  [N1];
  bit                 m_ov;
  bit                 m_idle;
  logic [N1-1:0]      e_en;
  int                 e_addr [N1];
  logic [D_W_ACC-1:0] e_data [N1];
  bit                 e_rst;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input logic s, input logic [N1-1:0] v, input logic r);
    bit all_full;
    e_en  = '0;
    e_rst = r;
    if (r) begin
      m_phase = 0; m_ov = 0; m_idle = 0;
      for (int i = 0; i < N1; i++) begin
        m_cnt[i] = 0; e_addr[i] = 0; e_data[i] = '0;
      end
    end else begin
      case (m_phase)
        0: begin
          if (s) begin
            m_phase = 1; m_ov = 0; m_idle = 0;
            for (int i = 0; i < N1; i++) m_cnt[i] = 0;
          end
          if (v != '0) m_idle = 1;
        end
        1: begin
          all_full = 1;
          for (int i = 0; i < N1; i++) begin
            if (v[i]) begin
              if (m_cnt[i] < DEPTH) begin
                e_en[i]   = 1'b1;
                e_addr[i] = m_cnt[i];
                e_data[i] = bus.D[i];
                m_cnt[i]++;
              end else begin
                m_ov = 1;
              end
            end
            if (m_cnt[i] != DEPTH) all_full = 0;
          end
          if (all_full) m_phase = 2;
        end
        default: begin
          if (v != '0) m_idle = 1;
          m_phase = 0;
        end
      endcase
    end
  endtask

  task automatic compare_all();
    check("wr_en", 32'(bus.wr_en), 32'(e_en));
    for (int i = 0; i < N1; i++) begin
      if (e_en[i] || e_rst) begin
        check($sformatf("wr_addr[%0d]", i), 32'(bus.wr_addr[i]), 32'(e_addr[i]));
        check($sformatf("wr_data[%0d]", i), 32'(bus.wr_data[i]), 32'(e_data[i]));
      end
    end
    check("busy",         32'(bus.busy),         32'(m_phase == 1));
    check("done",         32'(bus.done),         32'(m_phase == 2));
    check("err_overflow", 32'(bus.err_overflow), 32'(m_ov));
    check("err_idle",     32'(bus.err_idle),     32'(m_idle));
  endtask

  // Inputs are applied 1 time unit after a rising edge; outputs are checked 1 unit after the next.
  task automatic cycle(input logic s, input logic [N1-1:0] v, input logic r);
    bus.start   = s;
    bus.valid_D = v;
    rst         = r;
    model_step(s, v, r);
    @(posedge clk);
    #1;
    compare_all();
    if (bus.done) done_cnt++;
    bus.start   = 1'b0;
    bus.valid_D = '0;
    rst         = 1'b0;
  endtask

  task automatic rand_data();
    for (int i = 0; i < N1; i++) bus.D[i] = D_W_ACC'($urandom);
  endtask

  initial begin
    logic [N1-1:0] v;
    int k;
    bus.start = 1'b0; bus.valid_D = '0; rst = 1'b1;
    for (int i = 0; i < N1; i++) bus.D[i] = '0;

    // Reset state
    cycle(1'b0, '0, 1'b1);
    cycle(1'b0, '0, 1'b1);
    cycle(1'b0, '0, 1'b0);

    // Staggered lanes, lane i delayed i cycles, D = lane*100 + k
    done_cnt = 0;
    cycle(1'b1, '0, 1'b0);
    for (int t = 0; t < DEPTH + N1 - 1; t++) begin
      v = '0;
      for (int i = 0; i < N1; i++) begin
        k = t - i;
        bus.D[i] = '0;
        if (k >= 0 && k < DEPTH) begin
          v[i] = 1'b1;
          bus.D[i] = D_W_ACC'(i * 100 + k);
        end
      end
      cycle(1'b0, v, 1'b0);
    end
    check("stagger_done_count", 32'(done_cnt), 32'd1);
    cycle(1'b0, '0, 1'b0);

    // All lanes every cycle: done right after 16th beat, busy low afterwards
    done_cnt = 0;
    cycle(1'b1, '0, 1'b0);
    for (int t = 0; t < DEPTH; t++) begin
      rand_data();
      cycle(1'b0, '1, 1'b0);
    end
    check("full_done_now", 32'(bus.done), 32'd1);
    cycle(1'b0, '0, 1'b0);
    check("full_busy_after", 32'(bus.busy), 32'd0);
    check("full_done_count", 32'(done_cnt), 32'd1);

    // Lane 0 overruns while lane 3 lags by 8 cycles
    done_cnt = 0;
    cycle(1'b1, '0, 1'b0);
    for (int t = 0; t < DEPTH + 8; t++) begin
      rand_data();
      v = '0;
      if (t < DEPTH) v[2:0] = 3'b111;
      if (t == DEPTH) v[0] = 1'b1;
      if (t >= 8) v[3] = 1'b1;
      cycle(1'b0, v, 1'b0);
    end
    check("ovf_flag", 32'(bus.err_overflow), 32'd1);
    check("ovf_done_count", 32'(done_cnt), 32'd1);
    cycle(1'b0, '0, 1'b0);

    // Beats with no start, then start clears err_idle
    rand_data();
    cycle(1'b0, '1, 1'b0);
    check("idle_flag", 32'(bus.err_idle), 32'd1);
    cycle(1'b1, '0, 1'b0);
    check("idle_cleared", 32'(bus.err_idle), 32'd0);

    // Reset mid-matrix, then a clean full matrix
    done_cnt = 0;
    for (int t = 0; t < 8; t++) begin
      rand_data();
      cycle(1'b0, '1, 1'b0);
    end
    cycle(1'b0, '0, 1'b1);
    cycle(1'b1, '0, 1'b0);
    for (int t = 0; t < DEPTH; t++) begin
      rand_data();
      cycle(1'b0, '1, 1'b0);
    end
    check("rst_done_count", 32'(done_cnt), 32'd1);
    check("rst_no_ovf", 32'(bus.err_overflow), 32'd0);
    check("rst_no_idle", 32'(bus.err_idle), 32'd0);
    cycle(1'b0, '0, 1'b0);

    // Second start mid-collect is ignored
    done_cnt = 0;
    cycle(1'b1, '0, 1'b0);
    for (int t = 0; t < DEPTH; t++) begin
      rand_data();
      cycle(t == 5 || t == 9, '1, 1'b0);
      if (t < DEPTH - 1) check("restart_no_early_done", 32'(done_cnt), 32'd0);
    end
    check("restart_done_count", 32'(done_cnt), 32'd1);
    cycle(1'b0, '0, 1'b0);

    // Randomized valid patterns with random overrun beats, bounded wait for done
    for (int rep = 0; rep < 3; rep++) begin
      done_cnt = 0;
      cycle(1'b1, '0, 1'b0);
      for (int t = 0; t < 400 && done_cnt == 0; t++) begin
        rand_data();
        cycle(1'b0, N1'($urandom), 1'b0);
      end
      check("rand_done_seen", 32'(done_cnt), 32'd1);
      for (int t = 0; t < 3; t++) begin
        rand_data();
        cycle(1'b0, N1'($urandom), 1'b0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
